// File: rtl/mac_accum_ctrl.sv
// mac_accum_ctrl: sequencer in front of the shared 34-bit carry-lookahead adder.
// Takes signed operand pairs, registers their sign-extended products and feeds them
// with the running accumulator to the external adder. After N_TERMS products it adds
// a round-half-up constant, then presents a saturated DATA_W-bit fixed-point result.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both
// high. The producer holds data stable while valid is high and ready is low. Ready
// never depends on valid on the same interface.
module mac_accum_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 34,
    parameter int N_TERMS = 4,
    parameter int FRAC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [ACC_W-1:0]  add_op_a,
    output logic [ACC_W-1:0]  add_op_b,
    output logic              add_cin,
    input  logic [ACC_W-1:0]  add_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(N_TERMS + 1);

    // FSM encoding
    localparam logic [1:0] ST_ACC = 2'd0;
    localparam logic [1:0] ST_RND = 2'd1;
    localparam logic [1:0] ST_OUT = 2'd2;

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

    // Round-half-up constant: half of one output LSB.
    localparam logic [ACC_W-1:0] RND_K = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    // Output clamp limits, sign-extended to accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

    logic [1:0]        state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  p_reg;
    logic              p_vld;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  done;

    logic                     in_hs;
    logic                     out_hs;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic                     over_hi;
    logic                     over_lo;

    // Product and its sign extension to the adder width.
    always_comb begin
        prod     = $signed(in_a) * $signed(in_b);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    // Handshake qualifiers; input side is only open while terms remain in the batch.
    always_comb begin
        in_ready = (state == ST_ACC) && (issued < N_LAST);
        in_hs    = in_valid && in_ready;
        out_hs   = out_valid && out_ready;
    end

    // Adder operand selection; carry-in is never used.
    always_comb begin
        add_op_a = acc;
        add_cin  = 1'b0;
        add_op_b = '0;
        if (state == ST_ACC && p_vld) begin
            add_op_b = p_reg;
        end else if (state == ST_RND) begin
            add_op_b = RND_K;
        end
    end

    // Scale down the rounded accumulator and clamp to the signed output range.
    always_comb begin
        shifted   = $signed(acc) >>> FRAC_W;
        over_hi   = shifted > SAT_MAX;
        over_lo   = shifted < SAT_MIN;
        out_valid = (state == ST_OUT);
        out_data  = '0;
        out_sat   = 1'b0;
        if (out_valid) begin
            if (over_hi) begin
                out_data = {1'b0, {(DATA_W-1){1'b1}}};
                out_sat  = 1'b1;
            end else if (over_lo) begin
                out_data = {1'b1, {(DATA_W-1){1'b0}}};
                out_sat  = 1'b1;
            end else begin
                out_data = shifted[DATA_W-1:0];
            end
        end
    end

    // Product pipeline register: one operand pair per cycle, bubble when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg  <= '0;
            p_vld  <= 1'b0;
            issued <= '0;
        end else begin
            p_vld <= in_hs;
            if (in_hs) begin
                p_reg  <= prod_ext;
                issued <= issued + 1'b1;
            end
            if (out_hs) begin
                issued <= '0;
            end
        end
    end

    // Batch FSM and accumulator write-back from the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
            acc   <= '0;
            done  <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (p_vld) begin
                        acc  <= add_sum;
                        done <= done + 1'b1;
                        if (done + 1'b1 == N_LAST) begin
                            state <= ST_RND;
                        end
                    end
                end
                ST_RND: begin
                    acc   <= add_sum;
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        acc   <= '0;
                        done  <= '0;
                        state <= ST_ACC;
                    end
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Testbench for mac_accum_ctrl: directed batches with hand-computed results,
// an ideal combinational adder model, and a queue-based result scoreboard.
module tb_mac_accum_ctrl;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 34;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [ACC_W-1:0]  add_op_a;
    logic [ACC_W-1:0]  add_op_b;
    logic              add_cin;
    logic [ACC_W-1:0]  add_sum;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sat;

    int vectors;
    int miscompares;

    logic [DATA_W:0] exp_q[$];

    mac_accum_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_op_a  (add_op_a),
        .add_op_b  (add_op_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    // Stand-in for the external carry-lookahead adder.
    assign add_sum = add_op_a + add_op_b + {{(ACC_W-1){1'b0}}, add_cin};

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: a result is consumed on the edge following a low-phase
    // sample that shows out_valid & out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {47'd0, out_sat, out_data}, 64'h1_dead_beef);
            end else begin
                check("result", {47'd0, out_sat, out_data}, {47'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver: present one pair and hold it until accepted.
    task automatic send_pair(input int a, input int b);
        int  n;
        logic got;
        in_valid = 1'b1;
        in_a     = a[DATA_W-1:0];
        in_b     = b[DATA_W-1:0];
        n        = 0;
        got      = 1'b0;
        do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 100);
        if (!got) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_four(input int a, input int b);
        for (int i = 0; i < 4; i++) send_pair(a, b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    int pat[7];
    int taken;

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b1;
        rst         = 1'b1;
        idle(2);

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_op_a", 64'(add_op_a), 64'd0);
        check("rst_op_b", 64'(add_op_b), 64'd0);
        rst = 1'b0;
        idle(1);

        // Basic batch with latency and adder operand checks
        exp_q.push_back({1'b0, 16'd1024});
        send_four(256, 256);
        check("lat_k_valid", 64'(out_valid), 64'd0);
        check("lat_k_op_a", 64'(add_op_a), 64'd196608);
        check("lat_k_op_b", 64'(add_op_b), 64'd65536);
        idle(1);
        check("lat_k1_valid", 64'(out_valid), 64'd0);
        check("lat_k1_op_a", 64'(add_op_a), 64'd262144);
        check("lat_k1_op_b", 64'(add_op_b), 64'd128);
        check("lat_k1_ready", 64'(in_ready), 64'd0);
        idle(1);
        check("lat_k2_valid", 64'(out_valid), 64'd1);
        check("lat_k2_op_b", 64'(add_op_b), 64'd0);
        check("add_cin", 64'(add_cin), 64'd0);
        wait_drain();

        // Rounding around the half-LSB point
        exp_q.push_back({1'b0, 16'h0001});
        send_pair(1, 128);  send_pair(0, 0); send_pair(0, 0); send_pair(0, 0);
        exp_q.push_back({1'b0, 16'h0000});
        send_pair(1, 127);  send_pair(0, 0); send_pair(0, 0); send_pair(0, 0);
        exp_q.push_back({1'b0, 16'hFFFF});
        send_pair(-1, 129); send_pair(0, 0); send_pair(0, 0); send_pair(0, 0);
        exp_q.push_back({1'b0, 16'h0000});
        send_pair(-1, 128); send_pair(0, 0); send_pair(0, 0); send_pair(0, 0);
        wait_drain();

        // Saturation and a large in-range value
        exp_q.push_back({1'b1, 16'h7FFF});
        send_four(32767, 32767);
        exp_q.push_back({1'b1, 16'h8000});
        send_four(-32768, 32767);
        exp_q.push_back({1'b0, 16'd508});
        send_four(127, 256);
        wait_drain();
        check("idle_out_data", 64'(out_data), 64'd0);
        check("idle_out_sat", 64'(out_sat), 64'd0);

        // Backpressure: result held, no adder activity, inputs blocked
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 16'd1024});
        send_four(256, 256);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", 64'(out_data), 64'd1024);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_op_a", 64'(add_op_a), 64'd262272);
            check("bp_op_b", 64'(add_op_b), 64'd0);
            idle(1);
        end
        out_ready = 1'b1;
        wait_drain();
        exp_q.push_back({1'b0, 16'd1024});
        send_four(256, 256);
        wait_drain();

        // Bubbles in in_valid
        pat   = '{1, 0, 0, 1, 1, 0, 1};
        taken = 0;
        exp_q.push_back({1'b0, 16'd1024});
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i][0];
            in_a     = 16'd256;
            in_b     = 16'd256;
            @(negedge clk);
            if (in_valid && in_ready) taken++;
            @(posedge clk);
            #1;
        end
        check("bub_ready_drop", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_a     = 16'd100;
        in_b     = 16'd100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) taken++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bub_taken", 64'(taken), 64'd4);
        wait_drain();

        // Asynchronous reset mid-batch
        send_pair(256, 256);
        send_pair(256, 256);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_op_a", 64'(add_op_a), 64'd0);
        check("mid_rst_op_b", 64'(add_op_b), 64'd0);
        idle(1);
        rst = 1'b0;
        idle(1);
        exp_q.push_back({1'b0, 16'd1024});
        send_four(256, 256);
        wait_drain();

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
